// File: rtl/alu_command_queue.sv
// Command FIFO feeding an external combinational ALU, with a registered
// result stage that holds steady under downstream backpressure.
module alu_command_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_a,
    input  logic [1:0]               cmd_b,
    input  logic [1:0]               cmd_select,
    output logic [1:0]               alu_a,
    output logic [1:0]               alu_b,
    output logic [1:0]               alu_select,
    input  logic [3:0]               alu_z,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_z,
    output logic [1:0]               res_select,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               done_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] sel;
    } cmd_t;

    cmd_t            cmdMem_q [DEPTH];
    logic [PW-1:0]   headPtr_q, headPtr_d;
    logic [PW-1:0]   tailPtr_q, tailPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            resValid_q, resValid_d;
    logic [3:0]      resZ_q, resZ_d;
    logic [1:0]      resSel_q, resSel_d;
    logic [7:0]      doneCount_q, doneCount_d;

    logic            notEmpty;
    logic            push;
    logic            issue;
    logic            accept;
    cmd_t            headEntry;

    assign notEmpty  = (count_q != '0);
    assign cmd_ready = (count_q < FULL_C);
    assign push      = cmd_valid && cmd_ready;
    assign issue     = notEmpty && (!resValid_q || res_ready);
    assign accept    = resValid_q && res_ready;
    assign headEntry = cmdMem_q[headPtr_q];

    // The ALU only ever sees the stored head, never the incoming command.
    assign alu_a      = notEmpty ? headEntry.a   : 2'b00;
    assign alu_b      = notEmpty ? headEntry.b   : 2'b00;
    assign alu_select = notEmpty ? headEntry.sel : 2'b00;

    assign res_valid  = resValid_q;
    assign res_z      = resZ_q;
    assign res_select = resSel_q;
    assign count      = count_q;
    assign done_count = doneCount_q;

    always_ff @(posedge clk) begin
        if (push) begin
            cmdMem_q[tailPtr_q] <= '{a: cmd_a, b: cmd_b, sel: cmd_select};
        end
    end

    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (push) begin
            tailPtr_d = tailPtr_q + PW'(1);
        end
        if (issue) begin
            headPtr_d = headPtr_q + PW'(1);
        end
        case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A new issue takes priority over clearing; both may coincide with an accept.
    always_comb begin
        resValid_d  = resValid_q;
        resZ_d      = resZ_q;
        resSel_d    = resSel_q;
        doneCount_d = doneCount_q;
        if (issue) begin
            resValid_d = 1'b1;
            resZ_d     = alu_z;
            resSel_d   = alu_select;
        end else if (accept) begin
            resValid_d = 1'b0;
        end
        if (accept) begin
            doneCount_d = doneCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            count_q     <= '0;
            resValid_q  <= 1'b0;
            resZ_q      <= '0;
            resSel_q    <= '0;
            doneCount_q <= '0;
        end else begin
            headPtr_q   <= headPtr_d;
            tailPtr_q   <= tailPtr_d;
            count_q     <= count_d;
            resValid_q  <= resValid_d;
            resZ_q      <= resZ_d;
            resSel_q    <= resSel_d;
            doneCount_q <= doneCount_d;
        end
    end

endmodule

// File: tb/tb_alu_command_queue.sv
// Directed bench for alu_command_queue: vector table plus hand-written
// backpressure, reset and wrap-around sequences against a bench-side ALU.
module tb_alu_command_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       cmdValid;
    logic       cmdReady;
    logic [1:0] cmdA, cmdB, cmdSel;
    logic [1:0] aluA, aluB, aluSel;
    logic [3:0] aluZ;
    logic       resValid;
    logic       resReady;
    logic [3:0] resZ;
    logic [1:0] resSel;
    logic [2:0] count;
    logic [7:0] doneCount;

    int compared = 0;
    int failed   = 0;

    alu_command_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_a      (cmdA),
        .cmd_b      (cmdB),
        .cmd_select (cmdSel),
        .alu_a      (aluA),
        .alu_b      (aluB),
        .alu_select (aluSel),
        .alu_z      (aluZ),
        .res_valid  (resValid),
        .res_ready  (resReady),
        .res_z      (resZ),
        .res_select (resSel),
        .count      (count),
        .done_count (doneCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] aluModel(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] s);
        logic [1:0] t;
        case (s)
            2'b11:   return {2'b00, a} * {2'b00, b};
            2'b10:   return {2'b00, a} + {2'b00, b};
            2'b01:   begin t = ~(a & b); return {2'b00, t}; end
            default: begin t = ~a; return {2'b00, t}; end
        endcase
    endfunction

    // External ALU seen by the queue.
    always_comb aluZ = aluModel(aluA, aluB, aluSel);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive inputs, take one rising edge, return 1 time unit after it.
    task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] s, input logic rr);
        cmdValid = v;
        cmdA     = a;
        cmdB     = b;
        cmdSel   = s;
        resReady = rr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int v, a, b, s, rr;
        int cnt, rv, z, rs, done, rdy;
    } vec_t;

    vec_t vecs[15];

    int bpA[6]  = '{3, 1, 2, 0, 3, 2};
    int bpB[6]  = '{3, 2, 1, 3, 0, 1};
    int bpS[6]  = '{3, 2, 3, 1, 0, 2};
    int bpZ[5]  = '{9, 3, 2, 3, 0};

    logic [3:0] wrapQ[$];
    logic [3:0] expZ;
    int         sent;
    int         got;
    logic       v;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //        v  a  b  s rr  cnt rv z rs done rdy
        vecs[0]  = '{1, 3, 3, 3, 1,  1, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 0, 0, 1,  0, 1, 9, 3, 0, 1};
        vecs[2]  = '{0, 0, 0, 0, 1,  0, 0, 9, 3, 1, 1};
        vecs[3]  = '{1, 3, 2, 2, 1,  1, 0, 9, 3, 1, 1};
        vecs[4]  = '{1, 2, 3, 1, 1,  1, 1, 5, 2, 1, 1};
        vecs[5]  = '{1, 1, 3, 0, 1,  1, 1, 1, 1, 2, 1};
        vecs[6]  = '{0, 0, 0, 0, 1,  0, 1, 2, 0, 3, 1};
        vecs[7]  = '{0, 0, 0, 0, 1,  0, 0, 2, 0, 4, 1};
        vecs[8]  = '{1, 1, 1, 3, 0,  1, 0, 2, 0, 4, 1};
        vecs[9]  = '{1, 2, 1, 2, 0,  1, 1, 1, 3, 4, 1};
        vecs[10] = '{1, 3, 1, 1, 0,  2, 1, 1, 3, 4, 1};
        vecs[11] = '{1, 0, 2, 0, 1,  2, 1, 3, 2, 5, 1};
        vecs[12] = '{0, 0, 0, 0, 1,  1, 1, 2, 1, 6, 1};
        vecs[13] = '{0, 0, 0, 0, 1,  0, 1, 3, 0, 7, 1};
        vecs[14] = '{0, 0, 0, 0, 1,  0, 0, 3, 0, 8, 1};

        reset    = 1'b1;
        cmdValid = 1'b0;
        cmdA     = 2'b00;
        cmdB     = 2'b00;
        cmdSel   = 2'b00;
        resReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset count", 32'(count), 0);
        checkOutput("reset res_valid", 32'(resValid), 0);
        checkOutput("reset res_z", 32'(resZ), 0);
        checkOutput("reset res_select", 32'(resSel), 0);
        checkOutput("reset done_count", 32'(doneCount), 0);
        checkOutput("reset cmd_ready", 32'(cmdReady), 1);
        checkOutput("reset alu_a", 32'(aluA), 0);
        checkOutput("reset alu_select", 32'(aluSel), 0);
        reset = 1'b0;

        // Single op, short stream, and simultaneous push/pop at count 2.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'(vecs[i].v), 2'(vecs[i].a), 2'(vecs[i].b), 2'(vecs[i].s),
                          1'(vecs[i].rr));
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d cmd_ready", i), 32'(cmdReady), 32'(vecs[i].rdy));
            checkOutput($sformatf("vec%0d res_valid", i), 32'(resValid), 32'(vecs[i].rv));
            checkOutput($sformatf("vec%0d res_z", i), 32'(resZ), 32'(vecs[i].z));
            checkOutput($sformatf("vec%0d res_select", i), 32'(resSel), 32'(vecs[i].rs));
            checkOutput($sformatf("vec%0d done_count", i), 32'(doneCount), 32'(vecs[i].done));
        end

        // Fill under backpressure; the last command must be refused.
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b1, 2'(bpA[i]), 2'(bpB[i]), 2'(bpS[i]), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput("full count", 32'(count), DEPTH);
            checkOutput("full cmd_ready", 32'(cmdReady), 0);
            checkOutput("full res_valid", 32'(resValid), 1);
            checkOutput("full res_z held", 32'(resZ), 9);
            checkOutput("full res_select held", 32'(resSel), 3);
            checkOutput("full alu_a head", 32'(aluA), 1);
            checkOutput("full alu_b head", 32'(aluB), 2);
            checkOutput("full alu_select head", 32'(aluSel), 2);
            applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        for (int k = 0; k < DEPTH + 1; k++) begin
            checkOutput($sformatf("drain%0d res_valid", k), 32'(resValid), 1);
            checkOutput($sformatf("drain%0d res_z", k), 32'(resZ), 32'(bpZ[k]));
            checkOutput($sformatf("drain%0d res_select", k), 32'(resSel), 32'(bpS[k]));
            applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        end
        checkOutput("drained res_valid", 32'(resValid), 0);
        checkOutput("drained count", 32'(count), 0);
        checkOutput("drained done_count", 32'(doneCount), 13);

        // Build count=3 with a pending result, then reset between edges.
        applyStimulus(1'b1, 2'd1, 2'd1, 2'd3, 1'b0);
        applyStimulus(1'b1, 2'd1, 2'd2, 2'd2, 1'b0);
        applyStimulus(1'b1, 2'd2, 2'd2, 2'd3, 1'b0);
        applyStimulus(1'b1, 2'd3, 2'd1, 2'd2, 1'b0);
        checkOutput("pre-reset count", 32'(count), 3);
        checkOutput("pre-reset res_valid", 32'(resValid), 1);
        cmdValid = 1'b0;
        #3 reset = 1'b1;
        #1;
        checkOutput("async reset count", 32'(count), 0);
        checkOutput("async reset res_valid", 32'(resValid), 0);
        checkOutput("async reset done_count", 32'(doneCount), 0);
        checkOutput("async reset cmd_ready", 32'(cmdReady), 1);
        checkOutput("async reset alu_a", 32'(aluA), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
            checkOutput("post-reset res_valid", 32'(resValid), 0);
            checkOutput("post-reset count", 32'(count), 0);
        end

        // Stream 260 commands at full rate; done_count must wrap to 4.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 260; cyc++) begin
            v = (sent < 260);
            applyStimulus(v, 2'(sent), 2'(sent >> 2), 2'(sent >> 4), 1'b1);
            if (v) begin
                wrapQ.push_back(aluModel(2'(sent), 2'(sent >> 2), 2'(sent >> 4)));
                sent++;
            end
            if (cyc == 0) begin
                checkOutput("first push count", 32'(count), 1);
            end
            if (resValid) begin
                expZ = (wrapQ.size() > 0) ? wrapQ.pop_front() : 4'bxxxx;
                checkOutput($sformatf("wrap%0d res_z", got), 32'(resZ), 32'(expZ));
                got++;
            end
        end
        checkOutput("wrap results received", got, 260);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        checkOutput("wrap done_count", 32'(doneCount), 4);
        checkOutput("wrap res_valid", 32'(resValid), 0);
        checkOutput("wrap count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/alu_command_queue.md
ALU_COMMAND_QUEUE -- requirements
Module: alu_command_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  queue can accept a command this cycle.
REQ-006 cmd_a  input  2  operand A.
REQ-007 cmd_b  input  2  operand B.
REQ-008 cmd_select  input  2  ALU op: 11 multiply, 10 add, 01 nand, 00 not A.
REQ-009 alu_a  output  2  operand A to ALU.
REQ-010 alu_b  output  2  operand B to ALU.
REQ-011 alu_select  output  2  op select to ALU.
REQ-012 alu_z  input  4  combinational ALU result for current alu_a/alu_b/alu_select.
REQ-013 res_valid  output  1  registered result available.
REQ-014 res_ready  input  1  downstream accepts result.
REQ-015 res_z  output  4  registered ALU result.
REQ-016 res_select  output  2  op select that produced res_z.
REQ-017 count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-018 done_count  output  8  number of results accepted downstream, wraps 255->0.

Function
REQ-019 Push: cmd_valid && cmd_ready at a rising edge writes {cmd_a,cmd_b,cmd_select} at the tail; cmd_ready SHALL be (count < DEPTH), combinational on count only.
REQ-020 Head: alu_a/alu_b/alu_select SHALL show the FIFO head entry when count>0, and 2'b00 each when count==0.
REQ-021 Issue condition: issue = (count>0) && (!res_valid || res_ready).
REQ-022 On issue at a rising edge: res_z <= alu_z, res_select <= alu_select, res_valid <= 1, head pointer advances.
REQ-023 When res_valid && res_ready and no issue: res_valid <= 0; res_z/res_select hold.
REQ-024 When !res_valid or !res_ready and no issue: res_valid, res_z, res_select hold (result stable under backpressure).
REQ-025 done_count SHALL increment by 1 on every edge where res_valid && res_ready, wrapping modulo 256.
REQ-026 Latency: command accepted at edge N, queue otherwise empty and res_ready=1 -> res_valid=1 with its result after edge N+1 (next cycle after head becomes visible); no same-cycle bypass from cmd_* to alu_*.
REQ-027 Throughput: with res_ready held 1 and FIFO non-empty, one result per cycle.
REQ-028 Simultaneous push and issue: count unchanged, both pointers advance; permitted at any count 1..DEPTH-1; at count==DEPTH push is blocked (cmd_ready=0) even if issue occurs that cycle.
REQ-029 Push at count==0 with issue impossible that cycle (count was 0): count becomes 1.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-031 res_z is alu_z captured unmodified (4 bits, no extension or saturation); ordering is strict FIFO.
REQ-032 cmd_valid with cmd_ready=0 SHALL have no effect; command data need not be held stable by this block's contract beyond the accepting edge.

Reset
REQ-033 reset high SHALL immediately (asynchronously) clear count, head/tail pointers, res_valid, res_z, res_select and done_count to 0; cmd_ready thus 1 and alu_* 0.
REQ-034 Reset mid-operation SHALL discard all queued commands and any pending result; no result emitted after release for pre-reset commands.
REQ-035 First push accepted at first rising edge with reset low.

Verification
REQ-036 Single op: push a=3,b=3,sel=11, res_ready=1 -> res_valid one cycle after head visible, res_z=9, res_select=11, done_count=1.
REQ-037 Stream: push (3,2,10),(2,3,01),(1,3,00) back-to-back, res_ready=1 -> res_z 5,1,2 on consecutive cycles, in order.
REQ-038 Full/backpressure: res_ready=0, push DEPTH+2 commands -> count=DEPTH, cmd_ready=0, res_valid=1 with first result held stable; release res_ready -> all DEPTH+1 results drained in order, none lost or duplicated.
REQ-039 Simultaneous push/pop at count=2 -> count stays 2 for that cycle, order preserved.
REQ-040 Reset asserted with count=3 and res_valid=1 (asynchronous, between edges) -> count=0, res_valid=0, done_count=0 immediately; no stale results after release.
REQ-041 Wrap: 260 results accepted -> done_count=4; pointers wrap with correct data throughout.
